// File: rtl/sprite_load_ctrl_if.sv
// Signal bundle between the sprite loader and its surroundings: the
// byte stream, the display's read ports and the two BRAM ports.
// The master side is the system (stream source plus display), the
// slave side is the load controller.
interface sprite_load_ctrl_if #(
    parameter int AW = 16
);
    logic          start_in;
    logic [7:0]    byte_in;
    logic          byte_valid_in;
    logic          byte_ready_out;
    logic          disp_active_in;
    logic [AW-1:0] disp_addr_in;
    logic [7:0]    pal_rd_addr_in;
    logic [AW-1:0] img_addr_out;
    logic          img_we_out;
    logic [7:0]    img_din_out;
    logic [7:0]    pal_addr_out;
    logic          pal_we_out;
    logic [23:0]   pal_din_out;
    logic          busy_out;
    logic          done_out;

    modport master (
        output start_in, byte_in, byte_valid_in, disp_active_in,
               disp_addr_in, pal_rd_addr_in,
        input  byte_ready_out, img_addr_out, img_we_out, img_din_out,
               pal_addr_out, pal_we_out, pal_din_out, busy_out, done_out
    );

    modport slave (
        input  start_in, byte_in, byte_valid_in, disp_active_in,
               disp_addr_in, pal_rd_addr_in,
        output byte_ready_out, img_addr_out, img_we_out, img_din_out,
               pal_addr_out, pal_we_out, pal_din_out, busy_out, done_out
    );
endinterface

// File: rtl/sprite_load_ctrl.sv
// Sprite load controller: streams a 256-entry RGB palette (three bytes
// per entry) followed by WIDTH*HEIGHT colour-id bytes into two BRAMs,
// sharing the BRAM address ports with the display. The display always
// wins: while it is active the stream is stalled and no write happens.
module sprite_load_ctrl #(
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 256
) (
    input  logic pixel_clk_in,
    input  logic rst_n_in,
    sprite_load_ctrl_if.slave bus
);
    localparam int N  = WIDTH * HEIGHT;
    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST_PIX = AW'(N - 1);
    localparam logic [7:0]    LAST_PAL = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PAL  = 2'd1,
        IMG  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [7:0]    pal_idx;
    logic [1:0]    phase;
    logic [AW-1:0] pix_idx;
    logic [7:0]    r_reg;
    logic [7:0]    g_reg;

    logic byte_ready;
    logic accept;
    logic start_load;
    logic pal_we;
    logic img_we;

    assign byte_ready = ((state == PAL) || (state == IMG)) && !bus.disp_active_in;
    assign accept     = bus.byte_valid_in && byte_ready;
    assign start_load = bus.start_in && ((state == IDLE) || (state == DONE));
    assign pal_we     = (state == PAL) && accept && (phase == 2'd2);
    assign img_we     = (state == IMG) && accept;

    assign bus.byte_ready_out = byte_ready;
    assign bus.pal_we_out     = pal_we;
    assign bus.pal_addr_out   = pal_we ? pal_idx : bus.pal_rd_addr_in;
    assign bus.pal_din_out    = {r_reg, g_reg, bus.byte_in};
    assign bus.img_we_out     = img_we;
    assign bus.img_addr_out   = img_we ? pix_idx : bus.disp_addr_in;
    assign bus.img_din_out    = bus.byte_in;
    assign bus.busy_out       = (state == PAL) || (state == IMG);
    assign bus.done_out       = (state == DONE);

    // State register; reset abandons any load in progress.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: last palette write moves on to the image, last pixel finishes.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (bus.start_in) begin
                    next_state = PAL;
                end
            end
            PAL: begin
                if (pal_we && (pal_idx == LAST_PAL)) begin
                    next_state = IMG;
                end
            end
            IMG: begin
                if (img_we && (pix_idx == LAST_PIX)) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: byte phase, R/G holding registers and the two write indices.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pal_idx <= '0;
            phase   <= '0;
            pix_idx <= '0;
            r_reg   <= '0;
            g_reg   <= '0;
        end else if (start_load) begin
            pal_idx <= '0;
            phase   <= '0;
            pix_idx <= '0;
            r_reg   <= '0;
            g_reg   <= '0;
        end else if (accept) begin
            if (state == PAL) begin
                case (phase)
                    2'd0: begin
                        r_reg <= bus.byte_in;
                        phase <= 2'd1;
                    end
                    2'd1: begin
                        g_reg <= bus.byte_in;
                        phase <= 2'd2;
                    end
                    default: begin
                        phase <= 2'd0;
                        if (pal_idx != LAST_PAL) begin
                            pal_idx <= pal_idx + 8'd1;
                        end
                    end
                endcase
            end else if (state == IMG) begin
                if (pix_idx != LAST_PIX) begin
                    pix_idx <= pix_idx + AW'(1);
                end
            end
        end
    end
endmodule

// File: doc/sprite_load_ctrl.md
SPRITE_LOAD_CTRL -- requirements
Module: sprite_load_ctrl

Interface
REQ-001 The module SHALL have parameter WIDTH, default 256, meaning the sprite width in pixels.
REQ-002 The module SHALL have parameter HEIGHT, default 256, meaning the sprite height in pixels; define N = WIDTH*HEIGHT and AW = $clog2(N).
REQ-003 The module SHALL have the following ports, one per line: name  direction  width  meaning.
- pixel_clk_in  input  1  single clock; all state changes on its rising edge.
- rst_n_in  input  1  reset, asynchronous, active-low.
- start_in  input  1  single-cycle request to begin a load.
- byte_in  input  8  load stream data.
- byte_valid_in  input  1  byte_in holds a valid byte.
- byte_ready_out  output  1  controller accepts byte_in this cycle.
- disp_active_in  input  1  display owns both BRAMs this cycle (sprite region).
- disp_addr_in  input  AW  display image read address.
- pal_rd_addr_in  input  8  display palette read address.
- img_addr_out  output  AW  image BRAM address.
- img_we_out  output  1  image BRAM write enable.
- img_din_out  output  8  image BRAM write data (colour id).
- pal_addr_out  output  8  palette BRAM address.
- pal_we_out  output  1  palette BRAM write enable.
- pal_din_out  output  24  palette BRAM write data {R,G,B}.
- busy_out  output  1  load in progress.
- done_out  output  1  load completed and not yet restarted.

Function
REQ-004 The FSM SHALL have states IDLE, PAL, IMG and DONE.
REQ-005 IDLE -> PAL on start_in; DONE -> PAL on start_in; start_in SHALL be ignored in PAL and IMG.
REQ-006 Entry into PAL SHALL clear the palette index, the byte phase (0..2), the pixel index and done_out.
REQ-007 byte_ready_out SHALL be (state is PAL or IMG) AND NOT disp_active_in, combinationally.
REQ-008 A byte is accepted only in a cycle with byte_valid_in AND byte_ready_out; no other byte SHALL change any state.
REQ-009 PAL: accepted bytes arrive in R, G, B order; R and G are registered; on the accepted B byte pal_we_out SHALL be 1 in that same cycle with pal_addr_out = palette index and pal_din_out = {R_reg, G_reg, byte_in}.
REQ-010 The palette index SHALL increment after each write; the write at index 255 SHALL move the FSM to IMG on the next edge.
REQ-011 IMG: each accepted byte SHALL assert img_we_out in the same cycle with img_addr_out = pixel index and img_din_out = byte_in; the pixel index increments afterwards.
REQ-012 The write at pixel index N-1 SHALL move the FSM to DONE; done_out SHALL be 1 throughout DONE and 0 in every other state.
REQ-013 When img_we_out is 0, img_addr_out SHALL equal disp_addr_in; when pal_we_out is 0, pal_addr_out SHALL equal pal_rd_addr_in (zero-latency mux).
REQ-014 img_we_out and pal_we_out SHALL never be 1 while disp_active_in is 1.
REQ-015 A partial R/G triplet SHALL be held across any number of stall cycles (disp_active_in high or byte_valid_in low) without loss.
REQ-016 busy_out SHALL be 1 exactly in PAL and IMG.
REQ-017 Index counters SHALL NOT wrap: they are bounded by the PAL->IMG and IMG->DONE transitions.

Reset
REQ-018 While rst_n_in is 0, the FSM SHALL go to IDLE immediately (asynchronously), with all counters, the byte phase, R_reg and G_reg at 0, and byte_ready_out, busy_out, done_out, img_we_out and pal_we_out at 0.
REQ-019 A reset during PAL or IMG SHALL abandon the load; BRAM contents already written are not cleared; the next start_in restarts from palette index 0.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- WIDTH=HEIGHT=4: start, stream 768+16 bytes with no stalls -> 256 pal writes, last {FF,00,80} at addr 255; 16 img writes at addrs 0..15; done_out=1 from cycle after 784th byte.
- disp_active_in high for 5 cycles between G and B of triplet 7 -> byte_ready_out=0, no writes; B then writes {R,G,B} at pal addr 7.
- byte_valid_in high in IDLE and DONE -> byte_ready_out=0, no writes; start_in mid-IMG -> ignored, pixel index unchanged.
- Idle mux: disp_addr_in=0x2A, pal_rd_addr_in=0x11 -> img_addr_out=0x2A, pal_addr_out=0x11, both we=0.
- rst_n_in low mid-IMG at pixel 9 -> outputs zero without a clock edge; restart writes pal addr 0 first.
- start_in in DONE -> done_out=0 next cycle, busy_out=1, full reload succeeds.
